// File: rtl/qspis_pkg.sv
// Shared definitions for the QSPI-slave Wishbone arbiter: bus widths and
// the arbiter state encoding.
package qspis_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_e;

endpackage

// File: rtl/qspis_wb_wdog.sv
// Bus-timeout watchdog: counts granted cycles without a response and flags
// expiry when the count reaches TIMEOUT. TIMEOUT=0 disables it entirely.
module qspis_wb_wdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    input  logic done_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);
    localparam bit              WD_ON = (TIMEOUT != 0);

    logic [TO_W-1:0] tmr_q;
    logic [TO_W-1:0] tmr_d;

    // Saturate at LIMIT so the counter never wraps even if the grant lingers.
    always_comb begin
        tmr_d = tmr_q;
        if (!WD_ON || clr_i) begin
            tmr_d = '0;
        end else if (en_i && !done_i && (tmr_q != LIMIT)) begin
            tmr_d = tmr_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign expire_o = WD_ON && en_i && !done_i && (tmr_q == LIMIT);

endmodule

// File: rtl/qspis_wb_arb.sv
// Two-master round-robin Wishbone arbiter placed between the QSPI bridge and
// the chip interconnect, with a watchdog that errors out hung cycles.
module qspis_wb_arb
    import qspis_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic             sys_clk,
    input  logic             rst_n,

    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic             m0_we_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,

    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic             m1_we_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,

    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic             s_we_o,
    output logic [DAT_W-1:0] s_dat_o,
    output logic [SEL_W-1:0] s_sel_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,
    input  logic             s_err_i,

    output logic             timeout_o,
    output logic             to_mst_o
);

    arb_state_e state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic       to_mst_q, to_mst_d;

    logic req0, req1;
    logic wd_en, wd_clr, wd_done, wd_expire;

    assign req0    = m0_cyc_i & m0_stb_i;
    assign req1    = m1_cyc_i & m1_stb_i;
    assign wd_en   = ((state_q == GNT0) && m0_cyc_i) || ((state_q == GNT1) && m1_cyc_i);
    assign wd_done = s_ack_i | s_err_i;

    qspis_wb_wdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wdog (
        .clk_i    (sys_clk),
        .rst_ni   (rst_n),
        .en_i     (wd_en),
        .clr_i    (wd_clr),
        .done_i   (wd_done),
        .expire_o (wd_expire)
    );

    // Every grant returns through IDLE, so a persistent requester re-competes
    // and continuous contention alternates strictly.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        to_mst_d   = to_mst_q;
        wd_clr     = 1'b0;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_adr_o    = '0;
        s_we_o     = 1'b0;
        s_dat_o    = '0;
        s_sel_o    = '0;
        m0_dat_o   = '0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m1_dat_o   = '0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0 && (!req1 || last_gnt_q)) begin
                    state_d    = GNT0;
                    last_gnt_d = 1'b0;
                    wd_clr     = 1'b1;
                end else if (req1) begin
                    state_d    = GNT1;
                    last_gnt_d = 1'b1;
                    wd_clr     = 1'b1;
                end
            end
            GNT0: begin
                s_cyc_o  = m0_cyc_i & ~wd_expire;
                s_stb_o  = m0_stb_i & ~wd_expire;
                s_adr_o  = m0_adr_i;
                s_we_o   = m0_we_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_dat_o = s_dat_i;
                m1_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | wd_expire;
                if (wd_done || !m0_cyc_i || wd_expire) begin
                    state_d = IDLE;
                end
                if (wd_expire) begin
                    to_mst_d = 1'b0;
                end
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i & ~wd_expire;
                s_stb_o  = m1_stb_i & ~wd_expire;
                s_adr_o  = m1_adr_i;
                s_we_o   = m1_we_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m0_dat_o = s_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | wd_expire;
                if (wd_done || !m1_cyc_i || wd_expire) begin
                    state_d = IDLE;
                end
                if (wd_expire) begin
                    to_mst_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            to_mst_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            to_mst_q   <= to_mst_d;
        end
    end

    assign timeout_o = wd_expire;
    assign to_mst_o  = to_mst_q;

endmodule

// File: tb/tb_qspis_wb_arb.sv
// Directed bench for qspis_wb_arb: completions are predicted into a queue as
// stimulus is applied and retired by a monitor when the DUT responds.
module tb_qspis_wb_arb;

    localparam int unsigned TO = 8;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;

    logic        m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
    logic [31:0] m0_adr_i = '0, m0_dat_i = '0;
    logic [3:0]  m0_sel_i = '0;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o, m0_err_o;

    logic        m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
    logic [31:0] m1_adr_i = '0, m1_dat_i = '0;
    logic [3:0]  m1_sel_i = '0;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o, m1_err_o;

    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_i = '0;
    logic        s_ack_i = 1'b0, s_err_i = 1'b0;

    logic        timeout_o, to_mst_o;

    always #5 sys_clk = ~sys_clk;

    qspis_wb_arb #(
        .TIMEOUT (TO),
        .TO_W    (8)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .m0_cyc_i  (m0_cyc_i),
        .m0_stb_i  (m0_stb_i),
        .m0_adr_i  (m0_adr_i),
        .m0_we_i   (m0_we_i),
        .m0_dat_i  (m0_dat_i),
        .m0_sel_i  (m0_sel_i),
        .m0_dat_o  (m0_dat_o),
        .m0_ack_o  (m0_ack_o),
        .m0_err_o  (m0_err_o),
        .m1_cyc_i  (m1_cyc_i),
        .m1_stb_i  (m1_stb_i),
        .m1_adr_i  (m1_adr_i),
        .m1_we_i   (m1_we_i),
        .m1_dat_i  (m1_dat_i),
        .m1_sel_i  (m1_sel_i),
        .m1_dat_o  (m1_dat_o),
        .m1_ack_o  (m1_ack_o),
        .m1_err_o  (m1_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_adr_o   (s_adr_o),
        .s_we_o    (s_we_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .timeout_o (timeout_o),
        .to_mst_o  (to_mst_o)
    );

    // resp bits are {m0_ack, m0_err, m1_ack, m1_err}
    typedef struct {
        logic [3:0]  resp;
        bit          chkDat;
        logic [31:0] dat;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    logic [3:0] monResp;
    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkOutputBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pushExp(input logic [3:0] resp, input bit chkDat, input logic [31:0] dat);
        exp_t e;
        e.resp   = resp;
        e.chkDat = chkDat;
        e.dat    = dat;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input int mst, input logic cyc, input logic stb, input logic we,
                                 input logic [31:0] adr, input logic [31:0] dat);
        if (mst == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
            m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = 4'hF;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
            m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = 4'hF;
        end
    endtask

    // Run n granted cycles; slave answers (ackLast/errLast) on the last one.
    // expectTo marks that the last cycle must be a watchdog expiry instead.
    task automatic waitGrant(input string tag, input int n, input logic ackLast, input logic errLast,
                             input logic [3:0] resp, input bit expectTo);
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k == n) begin
                s_ack_i = ackLast;
                s_err_i = errLast;
                pushExp(resp, 1'b0, '0);
            end
            #1;
            checkOutputBit({tag, "_timeout"}, timeout_o, (k == n) && expectTo);
            checkOutputBit({tag, "_cyc"}, s_cyc_o, !((k == n) && expectTo));
        end
        tick();
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        #1;
        checkOutputBit({tag, "_idle_after"}, s_cyc_o, 1'b0);
    endtask

    always @(negedge sys_clk) begin
        monResp = {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o};
        if (monResp != 4'b0000) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_completion", {28'd0, monResp}, 32'd0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("completion", {28'd0, monResp}, {28'd0, monExp.resp});
                if (monExp.chkDat)
                    checkOutput("rdata", (monExp.resp[1] ? m1_dat_o : m0_dat_o), monExp.dat);
            end
        end
    end

    initial begin
        #12;
        checkOutput("reset_ctrl", {24'd0, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, timeout_o, to_mst_o}, 32'd0);
        checkOutput("reset_adr", s_adr_o, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] single master write");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h3000_0010, 32'hA5A5_5A5A);
        #1;
        checkOutputBit("t1_stb_before_grant", s_stb_o, 1'b0);
        tick();
        #1;
        checkOutputBit("t1_stb", s_stb_o, 1'b1);
        checkOutput("t1_adr", s_adr_o, 32'h3000_0010);
        checkOutput("t1_dat", s_dat_o, 32'hA5A5_5A5A);
        checkOutputBit("t1_we", s_we_o, 1'b1);
        checkOutput("t1_sel", {28'd0, s_sel_o}, 32'hF);
        tick();
        tick();
        s_ack_i = 1'b1;
        pushExp(4'b1000, 1'b0, '0);
        tick();
        s_ack_i = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        checkOutputBit("t1_done", s_cyc_o, 1'b0);

        $display("[TB] m1 read");
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h1000_0004, '0);
        tick();
        #1;
        checkOutput("t3_adr", s_adr_o, 32'h1000_0004);
        checkOutputBit("t3_we", s_we_o, 1'b0);
        s_dat_i = 32'hDEAD_BEEF;
        s_ack_i = 1'b1;
        pushExp(4'b0010, 1'b1, 32'hDEAD_BEEF);
        #1;
        checkOutputBit("t3_m0_noack", m0_ack_o, 1'b0);
        tick();
        s_ack_i = 1'b0;
        s_dat_i = '0;
        applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, '0);

        $display("[TB] contention");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h1111_1111);
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h2222_2222);
        s_ack_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            pushExp((i % 2 == 1) ? 4'b0010 : 4'b1000, 1'b0, '0);
            #1;
            checkOutput("t2_grant_adr", s_adr_o, (i % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100);
            checkOutputBit("t2_cyc", s_cyc_o, 1'b1);
            tick();
            #1;
            checkOutputBit("t2_idle_gap", s_cyc_o, 1'b0);
        end
        s_ack_i = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, '0);

        $display("[TB] m0 timeout with m1 waiting");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'hF000_0000, '0);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, '0);
        waitGrant("t4", TO + 1, 1'b0, 1'b0, 4'b0100, 1'b1);
        checkOutputBit("t4_to_mst", to_mst_o, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        #1;
        checkOutput("t4_m1_next", s_adr_o, 32'h0000_0200);
        s_ack_i = 1'b1;
        pushExp(4'b0010, 1'b0, '0);
        tick();
        s_ack_i = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, '0);

        $display("[TB] ack on expiry cycle");
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h1000_0008, '0);
        waitGrant("t5", TO + 1, 1'b1, 1'b0, 4'b0010, 1'b0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, '0);

        $display("[TB] m1 timeout");
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'hF000_0004, '0);
        waitGrant("t6", TO + 1, 1'b0, 1'b0, 4'b0001, 1'b1);
        checkOutputBit("t6_to_mst", to_mst_o, 1'b1);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, '0);

        $display("[TB] ack and err together");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h3000_0014, 32'h0BAD_F00D);
        waitGrant("t7", 2, 1'b1, 1'b1, 4'b1100, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);

        $display("[TB] cycle abort and stb-only request");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h3000_0020, '0);
        tick();
        #1;
        checkOutputBit("t8_granted", s_cyc_o, 1'b1);
        tick();
        m0_cyc_i = 1'b0;
        #1;
        checkOutputBit("t8_cyc_follows", s_cyc_o, 1'b0);
        checkOutputBit("t8_no_timeout", timeout_o, 1'b0);
        tick();
        tick();
        #1;
        checkOutputBit("t8_stb_only_ignored", s_stb_o, 1'b0);
        m0_cyc_i = 1'b1;
        #1;
        checkOutputBit("t8_idle", s_cyc_o, 1'b0);
        tick();
        #1;
        checkOutputBit("t8_regrant", s_cyc_o, 1'b1);
        s_ack_i = 1'b1;
        pushExp(4'b1000, 1'b0, '0);
        tick();
        s_ack_i = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);

        $display("[TB] async reset mid-grant");
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h3333_3333);
        tick();
        #1;
        checkOutputBit("t9_granted", s_cyc_o, 1'b1);
        #1;
        rst_n   = 1'b0;
        s_ack_i = 1'b1;
        #1;
        checkOutput("t9_reset_ctrl", {25'd0, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m1_err_o, timeout_o, to_mst_o}, 32'd0);
        checkOutput("t9_reset_adr", s_adr_o, 32'd0);
        tick();
        rst_n   = 1'b1;
        s_ack_i = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h4444_4444);
        tick();
        #1;
        checkOutput("t9_first_tie_m0", s_adr_o, 32'h0000_0100);
        s_ack_i = 1'b1;
        pushExp(4'b1000, 1'b0, '0);
        tick();
        s_ack_i = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();

        checkOutput("pending_completions", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qspis_wb_arb.md
Name: qspis_wb_arb

Overview:
Two-master Wishbone arbiter that shares one Wishbone fabric port between the QSPI-slave bridge master (m0) and a second debug/host master (m1, e.g. the UART-to-WB bridge).
- Grants one master per transaction using round-robin, and forwards that master's cycle to the fabric.
- Bus-timeout watchdog terminates hung cycles with an error, so an unanswered address cannot lock the QSPI host out.
- Sits between the QSPI bridge WB master port and the chip-level WB interconnect.

Parameters:
TIMEOUT, 255, cycles a granted cycle may wait for ack/err before forced termination; 0 disables the watchdog
TO_W, 8, timeout counter width; TIMEOUT must be < 2**TO_W

Ports:
sys_clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
m0_cyc_i  in  1  QSPI bridge cycle
m0_stb_i  in  1  QSPI bridge strobe
m0_adr_i  in  32  QSPI bridge address
m0_we_i  in  1  QSPI bridge write
m0_dat_i  in  32  QSPI bridge write data
m0_sel_i  in  4  QSPI bridge byte enable
m0_dat_o  out  32  read data to m0
m0_ack_o  out  1  ack to m0
m0_err_o  out  1  error to m0
m1_cyc_i, m1_stb_i, m1_adr_i, m1_we_i, m1_dat_i, m1_sel_i  in  1/1/32/1/32/4  second master request, same meaning as m0
m1_dat_o, m1_ack_o, m1_err_o  out  32/1/1  second master response
s_cyc_o  out  1  fabric cycle
s_stb_o  out  1  fabric strobe
s_adr_o  out  32  fabric address
s_we_o  out  1  fabric write
s_dat_o  out  32  fabric write data
s_sel_o  out  4  fabric byte enable
s_dat_i  in  32  fabric read data
s_ack_i  in  1  fabric ack
s_err_i  in  1  fabric error
timeout_o  out  1  one-cycle pulse on watchdog expiry
to_mst_o  out  1  master that timed out (0=m0, 1=m1), held until next timeout

Behaviour:
- Clock and reset: single clock sys_clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, last_gnt=1 (so m0 wins the first tie), tmr=0, to_mst_o=0.
  - All s_* outputs 0; all m*_ack_o/err_o 0; timeout_o 0.
- A master requests when mX_cyc_i & mX_stb_i.
- States: IDLE, GNT0, GNT1.
- IDLE:
  - One requester -> grant it.
  - Both requesting -> grant the master != last_gnt.
  - None -> stay in IDLE.
  - On grant: last_gnt updates and tmr clears.
- Grant latency: request sampled at edge N; GNTx is entered at N+1; s_stb_o is visible in the same cycle as GNTx.
- GNTx datapath:
  - s_cyc/stb/adr/we/dat/sel = mX inputs.
  - mX_ack_o = s_ack_i and mX_err_o = s_err_i (both combinational).
  - m0_dat_o = m1_dat_o = s_dat_i, since the read-data bus is shared.
  - The non-granted master sees ack=0 and err=0.
- GNTx exits to IDLE when any of the following occurs:
  - s_ack_i or s_err_i (both together = single completion, both forwarded);
  - mX_cyc_i drops (abort; the fabric sees cyc fall the same cycle);
  - timeout.
- Every transaction is followed by at least one IDLE cycle, so a master re-requesting immediately competes again. This gives strict alternation under continuous contention.
- Watchdog (TIMEOUT>0):
  - tmr increments each GNTx cycle without ack/err.
  - When tmr==TIMEOUT and s_ack_i=0 and s_err_i=0:
    - s_cyc_o/s_stb_o are forced 0 that cycle;
    - mX_err_o=1 for one cycle;
    - timeout_o=1 and to_mst_o<=X;
    - next state is IDLE.
  - Ack arriving on the expiry cycle wins: normal completion, no timeout.
  - With TIMEOUT=0, tmr is held at 0 and no timeout is ever generated.
- Reset asserted mid-transaction: immediately IDLE with all outputs 0. No completion is reported to either master.
- Request held with stb but no cyc is ignored.

Decomposition:
- Package qspis_pkg:
  - arbiter state encodings (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10);
  - WB width constants (ADR_W=32, DAT_W=32, SEL_W=4).
- One natural sub-module: qspis_wb_wdog.
  - Inputs: enable (granted), clear (grant), done (ack|err).
  - Output: expiry pulse.
  - Parameterised by TIMEOUT/TO_W.
- Arbitration FSM and the mux stay in qspis_wb_arb.

Test Plan:
- Single master: m0 write adr=0x3000_0010 dat=0xA5A5_5A5A sel=4'hF, slave acks 2 cycles after stb -> s_stb_o 1 cycle after request; s_adr_o/s_dat_o match; m0_ack_o one cycle; m1_ack_o stays 0.
- Contention: m0 and m1 both request continuously, 4 transactions each, slave acks immediately -> grants in order m0,m1,m0,m1...; one IDLE cycle between each; no master starved.
- Read data: m1 read adr=0x1000_0004, slave returns 0xDEAD_BEEF with ack -> m1_dat_o=0xDEAD_BEEF with m1_ack_o=1; m0 sees no ack.
- Timeout: TIMEOUT=8, m0 read to an unmapped address, no ack -> on the 9th granted cycle, m0_err_o=1 and timeout_o=1; to_mst_o=0; s_cyc_o drops; m1 is then granted next.
- Boundaries:
  - ack on exactly the expiry cycle -> normal ack, no err, timeout_o=0;
  - s_ack_i and s_err_i together -> both forwarded, single completion;
  - m0_cyc_i dropped mid-wait -> fabric cyc falls the same cycle, arbiter returns to IDLE.
- Async reset: assert rst_n=0 mid-GNT1 between clock edges -> all outputs 0 immediately; after release, first tie goes to m0.
